// File: rtl/tone_gen.sv
// Piano-key square-wave generator: picks the lowest pressed key, scales its half-period by
// octave, and toggles spk every half_reg ticks of the 5 MHz strobe, changing pitch only at phase ends.
module tone_gen #(
  parameter int CNT_W    = 16,
  parameter int MIN_HALF = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_5m,
  input  logic [7:0] key,
  input  logic [1:0] octave,
  output logic       spk,
  output logic       playing,
  output logic [2:0] note_idx
);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [2:0]         note_q, note_d;
  logic               spk_q, spk_d;
  logic               playing_q, playing_d;

  logic [2:0]         key_idx;
  logic [CNT_W-1:0]   key_half;
  logic               key_any;

  function automatic logic [2:0] prio_idx(input logic [7:0] k);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (k[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // One spare bit so the octave-down shift of the longest note cannot overflow before clamping.
  function automatic logic [CNT_W:0] octave_shift(input logic [CNT_W:0] base, input logic [1:0] oct);
    logic [CNT_W:0] adj;
    case (oct)
      2'b01:   adj = base >> 1;
      2'b10:   adj = base << 1;
      default: adj = base;
    endcase
    return adj;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W:0] v);
    logic [CNT_W:0] lim;
    lim = (CNT_W+1)'(MIN_HALF);
    if (v < lim) return lim[CNT_W-1:0];
    return v[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] half_lookup(input logic [2:0] idx, input logic [1:0] oct);
    logic [CNT_W:0] base;
    case (idx)
      3'd0:    base = (CNT_W+1)'(9556);
      3'd1:    base = (CNT_W+1)'(8513);
      3'd2:    base = (CNT_W+1)'(7584);
      3'd3:    base = (CNT_W+1)'(7159);
      3'd4:    base = (CNT_W+1)'(6378);
      3'd5:    base = (CNT_W+1)'(5682);
      3'd6:    base = (CNT_W+1)'(5062);
      default: base = (CNT_W+1)'(4778);
    endcase
    return clamp_half(octave_shift(base, oct));
  endfunction

  assign key_any  = (key != 8'd0);
  assign key_idx  = prio_idx(key);
  assign key_half = half_lookup(key_idx, octave);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    note_d    = note_q;
    spk_d     = spk_q;
    playing_d = (state_q == PLAY);
    case (state_q)
      IDLE: begin
        spk_d = 1'b0;
        if (key_any) begin
          half_d  = key_half;
          note_d  = key_idx;
          cnt_d   = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick_5m) begin
          if (cnt_q == half_q - CNT_W'(1)) begin
            // Phase boundary: the only point where pitch changes or release is honoured.
            cnt_d = '0;
            if (key_any) begin
              spk_d  = ~spk_q;
              half_d = key_half;
              note_d = key_idx;
            end else begin
              spk_d   = 1'b0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      note_q    <= 3'd0;
      spk_q     <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      note_q    <= note_d;
      spk_q     <= spk_d;
      playing_q <= playing_d;
    end
  end

  assign spk      = spk_q;
  assign playing  = playing_q;
  assign note_idx = note_q;

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream consumer of the 5 MHz strobe from the clock-divider stage.
- Converts the piano key bank (8 keys, one octave C4..C5) plus an octave select into a 50%-duty square wave for the speaker/buzzer.
- Counts only on strobe cycles, so the whole block runs on the 50 MHz system clock with no derived clocks.
- Note changes and key release take effect only at half-period boundaries, so the output never emits runt pulses.

Parameters:
- CNT_W, 16, width of half-period counter and latched period register.
- MIN_HALF, 16, smallest legal half-period after octave shift; computed values below this are clamped to it.

Ports:
- clk  input  1  50 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- tick_5m  input  1  one-clk-wide strobe, one per 10 clk cycles (5 MHz count enable)
- key  input  8  key levels, already synchronised; bit0=C4, bit1=D4, bit2=E4, bit3=F4, bit4=G4, bit5=A4, bit6=B4, bit7=C5
- octave  input  2  00=base, 01=up one octave, 10=down one octave, 11=base
- spk  output  1  square-wave speaker drive
- playing  output  1  high while state is PLAY
- note_idx  output  3  index of the note currently being sounded (latched)

Behaviour:
- Reset values: spk=0, playing=0, note_idx=0, cnt=0, half_reg=0, state=IDLE. Reset is asynchronous and may assert at any time, including mid-waveform; it returns to IDLE immediately with spk=0.
- Key priority: lowest set bit of key wins. Example: key=8'b0010_0100 selects E4 (idx 2).
- Half-period table, in ticks at 5 MHz:
  - C4 9556, D4 8513, E4 7584, F4 7159
  - G4 6378, A4 5682, B4 5062, C5 4778
- Octave adjustment:
  - 01: value >>1 (truncate).
  - 10: value <<1 (max 19112, fits CNT_W=16).
  - 00/11: unchanged.
  - Result below MIN_HALF is clamped to MIN_HALF.
- State IDLE:
  - spk=0, playing=0.
  - On any clk edge with key!=0: latch half_reg=table(idx, octave), note_idx=idx, cnt=0, go to PLAY. No tick is required for this transition.
  - playing rises on the following edge; spk stays 0.
- State PLAY: cnt advances only on clk edges where tick_5m=1. On a tick:
  - If cnt != half_reg-1: cnt=cnt+1.
  - If cnt == half_reg-1 (boundary): cnt=0, then:
    - If key!=0: spk toggles; half_reg/note_idx re-latched from the current key/octave. The new pitch applies from the next half-period.
    - If key==0: spk=0, go to IDLE. If spk was already 0, the boundary simply ends it.
- Each spk phase therefore lasts exactly half_reg ticks. The first rising edge of spk comes half_reg ticks after the PLAY entry.
- Changes to key/octave between boundaries are ignored. A release followed by a re-press before the boundary is invisible. Only the values sampled at the boundary tick matter.
- tick_5m held high continuously is legal: it counts every clk (used for fast simulation).
- No tick ever: PLAY holds cnt and spk indefinitely.
- Counter never exceeds half_reg-1. No wrap-around beyond the boundary.

Test Plan:
- Reset then key=8'b0010_0000, octave=00, tick every 10 clk: playing=1 two edges after the press; spk rises 5682 ticks (56820 clk) later; spk period = 113640 clk, duty exactly 50%.
- Same key with octave=01 gives half=2841 ticks; with octave=10 gives half=11364. Measure spk half-phases equal these ×10 clk.
- key=8'b1000_0001 → note_idx=0, half=9556. Switch key to 8'b0100_0000 mid-phase: the current phase finishes at 9556 ticks; the next phase is 5062 ticks; note_idx becomes 6 at that boundary.
- Playing A4, release key during a high phase: spk stays high until the boundary, then drops to 0 with playing=0; no further toggles. Release during a low phase: spk stays 0 and the block returns to IDLE at the boundary.
- Assert rst_n low for 3 clk mid-high-phase with tick_5m held high: spk=0, playing=0, note_idx=0 immediately (async, no clk edge). After release with the key still held, the block re-enters PLAY and the first toggle comes after the full half-period.
- tick_5m tied high, key=C5, octave=01: half=2389; spk toggles every 2389 clk. Hold tick_5m=0 for 1000 clk mid-phase: the phase stretches by exactly 1000 clk.
